cipher_io_driver: RTL and testbench

Host-side counterpart of the cipher I/O controller, driving the 32-bit word link from the initiator end. Accepts a command (key, nonce, AD/data block counts) and a stream of 128-bit AD/data blocks, and serializes them into 32-bit words. Deserializes the returned ciphertext blocks and the final tag into 128-bit results. Sits between the system bus/testbench host and the cipher core's I/O controller.

---
 rtl/cipher_io_driver.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cipher_io_driver.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_io_driver.sv
`default_nettype none
// ============================================================================
// Module   : cipher_io_driver
// Purpose  : Initiator-side driver for the 32-bit cipher word link. Sends the
//            key, the nonce and the AD/data blocks as MSW-first words, and
//            collects the returned ciphertext blocks and the final tag.
// Revision : 1.0 - initial release
// ============================================================================
module cipher_io_driver #(
  parameter int KEY_LENGTH  = 128,
  parameter int DATA_LENGTH = 128,
  parameter int LENGTH      = 32,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [KEY_LENGTH-1:0]  key_i,
  input  logic [KEY_LENGTH-1:0]  nonce_i,
  input  logic [CNT_W-1:0]       ad_blocks_i,
  input  logic [CNT_W-1:0]       data_blocks_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [DATA_LENGTH-1:0] blk_i,
  output logic                   res_valid_o,
  output logic                   res_is_tag_o,
  output logic [DATA_LENGTH-1:0] res_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [LENGTH-1:0]      tx_data_o,
  output logic [1:0]             tx_type_o,
  output logic                   tx_last_o,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic [LENGTH-1:0]      rx_data_i
);

  // Key and nonce travel through the same block-wide shift register as the
  // AD/data blocks, so KEY_LENGTH is expected to equal DATA_LENGTH.
  localparam int WPB  = DATA_LENGTH / LENGTH;
  localparam int WC_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int RX_W = DATA_LENGTH - LENGTH;

  localparam logic [1:0] TYPE_KEY   = 2'd0;
  localparam logic [1:0] TYPE_NONCE = 2'd1;
  localparam logic [1:0] TYPE_AD    = 2'd2;
  localparam logic [1:0] TYPE_DATA  = 2'd3;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SEND_KEY   = 4'd1,
    SEND_NONCE = 4'd2,
    LOAD_AD    = 4'd3,
    SEND_AD    = 4'd4,
    LOAD_DATA  = 4'd5,
    SEND_DATA  = 4'd6,
    RECV_DATA  = 4'd7,
    RECV_TAG   = 4'd8,
    FINISH     = 4'd9
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_LENGTH-1:0] tx_sr_q, tx_sr_d;
  logic [KEY_LENGTH-1:0]  nonce_q, nonce_d;
  logic [CNT_W-1:0]       ad_cnt_q, ad_cnt_d;
  logic [CNT_W-1:0]       data_cnt_q, data_cnt_d;
  logic [WC_W-1:0]        wcnt_q, wcnt_d;
  logic [RX_W-1:0]        rx_sr_q, rx_sr_d;
  logic [DATA_LENGTH-1:0] res_q, res_d;
  logic                   res_is_tag_q, res_is_tag_d;
  logic                   res_valid_q, res_valid_d;

  logic                   tx_hs;
  logic                   rx_hs;
  logic                   word_last;
  logic [DATA_LENGTH-1:0] tx_sr_shifted;
  state_t                 after_ad;

  // Handshake qualifiers and the shared word-position helpers.
  always_comb begin
    tx_hs         = tx_valid_o & tx_ready_i;
    rx_hs         = rx_valid_i & rx_ready_o;
    word_last     = (wcnt_q == WC_W'(WPB - 1));
    tx_sr_shifted = {tx_sr_q[DATA_LENGTH-LENGTH-1:0], {LENGTH{1'b0}}};
    // Once AD is exhausted, go to data if any, otherwise straight to the tag.
    after_ad      = (data_cnt_q != '0) ? LOAD_DATA : RECV_TAG;
  end

  // Link-side outputs are pure decodes of the state and the shift registers,
  // so they hold steadily whenever the consumer stalls.
  always_comb begin
    tx_valid_o  = (state_q == SEND_KEY) || (state_q == SEND_NONCE) ||
                  (state_q == SEND_AD)  || (state_q == SEND_DATA);
    blk_ready_o = (state_q == LOAD_AD)  || (state_q == LOAD_DATA);
    rx_ready_o  = (state_q == RECV_DATA) || (state_q == RECV_TAG);
    busy_o      = (state_q != IDLE) && (state_q != FINISH);
    done_o      = (state_q == FINISH);
    tx_data_o   = tx_sr_q[DATA_LENGTH-1 -: LENGTH];
    tx_last_o   = tx_valid_o & word_last;
    case (state_q)
      SEND_KEY:   tx_type_o = TYPE_KEY;
      SEND_NONCE: tx_type_o = TYPE_NONCE;
      SEND_AD:    tx_type_o = TYPE_AD;
      SEND_DATA:  tx_type_o = TYPE_DATA;
      default:    tx_type_o = 2'd0;
    endcase
    res_valid_o  = res_valid_q;
    res_is_tag_o = res_is_tag_q;
    res_o        = res_q;
  end

  // Next-state, shift-register and counter updates for the whole operation.
  always_comb begin
    state_d      = state_q;
    tx_sr_d      = tx_sr_q;
    nonce_d      = nonce_q;
    ad_cnt_d     = ad_cnt_q;
    data_cnt_d   = data_cnt_q;
    wcnt_d       = wcnt_q;
    rx_sr_d      = rx_sr_q;
    res_d        = res_q;
    res_is_tag_d = res_is_tag_q;
    res_valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_sr_d    = key_i;
          nonce_d    = nonce_i;
          ad_cnt_d   = ad_blocks_i;
          data_cnt_d = data_blocks_i;
          wcnt_d     = '0;
          state_d    = SEND_KEY;
        end
      end

      SEND_KEY: begin
        if (tx_hs) begin
          tx_sr_d = tx_sr_shifted;
          wcnt_d  = wcnt_q + WC_W'(1);
          if (word_last) begin
            tx_sr_d = nonce_q;
            state_d = SEND_NONCE;
          end
        end
      end

      SEND_NONCE: begin
        if (tx_hs) begin
          tx_sr_d = tx_sr_shifted;
          wcnt_d  = wcnt_q + WC_W'(1);
          if (word_last) begin
            state_d = (ad_cnt_q != '0) ? LOAD_AD : after_ad;
          end
        end
      end

      LOAD_AD: begin
        if (blk_valid_i) begin
          tx_sr_d = blk_i;
          state_d = SEND_AD;
        end
      end

      SEND_AD: begin
        if (tx_hs) begin
          tx_sr_d = tx_sr_shifted;
          wcnt_d  = wcnt_q + WC_W'(1);
          if (word_last) begin
            ad_cnt_d = ad_cnt_q - CNT_W'(1);
            state_d  = (ad_cnt_q > CNT_W'(1)) ? LOAD_AD : after_ad;
          end
        end
      end

      LOAD_DATA: begin
        if (blk_valid_i) begin
          tx_sr_d = blk_i;
          state_d = SEND_DATA;
        end
      end

      SEND_DATA: begin
        if (tx_hs) begin
          tx_sr_d = tx_sr_shifted;
          wcnt_d  = wcnt_q + WC_W'(1);
          if (word_last) begin
            state_d = RECV_DATA;
          end
        end
      end

      RECV_DATA: begin
        if (rx_hs) begin
          rx_sr_d = {rx_sr_q[RX_W-LENGTH-1:0], rx_data_i};
          wcnt_d  = wcnt_q + WC_W'(1);
          if (word_last) begin
            res_d        = {rx_sr_q, rx_data_i};
            res_is_tag_d = 1'b0;
            res_valid_d  = 1'b1;
            data_cnt_d   = data_cnt_q - CNT_W'(1);
            state_d      = (data_cnt_q > CNT_W'(1)) ? LOAD_DATA : RECV_TAG;
          end
        end
      end

      RECV_TAG: begin
        if (rx_hs) begin
          rx_sr_d = {rx_sr_q[RX_W-LENGTH-1:0], rx_data_i};
          wcnt_d  = wcnt_q + WC_W'(1);
          if (word_last) begin
            res_d        = {rx_sr_q, rx_data_i};
            res_is_tag_d = 1'b1;
            res_valid_d  = 1'b1;
            state_d      = FINISH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_sr_q      <= '0;
      nonce_q      <= '0;
      ad_cnt_q     <= '0;
      data_cnt_q   <= '0;
      wcnt_q       <= '0;
      rx_sr_q      <= '0;
      res_q        <= '0;
      res_is_tag_q <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_sr_q      <= tx_sr_d;
      nonce_q      <= nonce_d;
      ad_cnt_q     <= ad_cnt_d;
      data_cnt_q   <= data_cnt_d;
      wcnt_q       <= wcnt_d;
      rx_sr_q      <= rx_sr_d;
      res_q        <= res_d;
      res_is_tag_q <= res_is_tag_d;
      res_valid_q  <= res_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cipher_io_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_io_driver
// Purpose  : Self-checking bench for cipher_io_driver. Expected link words
//            and results are queued when an operation is prepared and popped
//            as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_io_driver;

  localparam int KL = 128;
  localparam int DL = 128;
  localparam int LW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [KL-1:0] key_i = '0;
  logic [KL-1:0] nonce_i = '0;
  logic [CW-1:0] ad_blocks_i = '0;
  logic [CW-1:0] data_blocks_i = '0;
  logic          blk_valid_i = 1'b0;
  logic          blk_ready_o;
  logic [DL-1:0] blk_i = '0;
  logic          res_valid_o;
  logic          res_is_tag_o;
  logic [DL-1:0] res_o;
  logic          busy_o;
  logic          done_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic [LW-1:0] tx_data_o;
  logic [1:0]    tx_type_o;
  logic          tx_last_o;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic [LW-1:0] rx_data_i = '0;

  cipher_io_driver #(
    .KEY_LENGTH(KL), .DATA_LENGTH(DL), .LENGTH(LW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i), .nonce_i(nonce_i),
    .ad_blocks_i(ad_blocks_i), .data_blocks_i(data_blocks_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_i(blk_i),
    .res_valid_o(res_valid_o), .res_is_tag_o(res_is_tag_o), .res_o(res_o),
    .busy_o(busy_o), .done_o(done_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
    .tx_type_o(tx_type_o), .tx_last_o(tx_last_o),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    typ;
    logic          last;
    logic [LW-1:0] data;
  } tx_exp_t;

  typedef struct {
    int na;
    int nd;
    bit rnd;
    int exp_words;
    int exp_res;
  } vec_t;

  tx_exp_t       txq[$];
  logic [DL:0]   resq[$];
  logic [DL-1:0] blkq[$];
  logic [LW-1:0] rxq[$];

  int  checks = 0;
  int  failures = 0;
  int  tx_cnt = 0;
  int  res_cnt = 0;
  int  done_cnt = 0;
  bit  blk_en = 1'b1;
  bit  rnd_rdy = 1'b0;
  bit  blk_take = 1'b0;
  bit  rx_take = 1'b0;
  bit  prev_stall = 1'b0;
  logic [34:0] prev_word = '0;

  task automatic chk(input string name, input logic [DL:0] act, input logic [DL:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Output monitor: word scoreboard, stall stability, results, done pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && tx_valid_o)
        chk("tx_hold", {tx_type_o, tx_last_o, tx_data_o}, prev_word);
      if (tx_valid_o && tx_ready_i) begin
        tx_cnt++;
        if (txq.size() == 0) flag_fail("tx_unexpected_word");
        else begin
          tx_exp_t e;
          e = txq.pop_front();
          chk("tx_word", {tx_type_o, tx_last_o, tx_data_o}, e);
        end
      end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_word  = {tx_type_o, tx_last_o, tx_data_o};
      if (res_valid_o) begin
        res_cnt++;
        if (resq.size() == 0) flag_fail("res_unexpected");
        else chk("res_block", {res_is_tag_o, res_o}, resq.pop_front());
      end
      if (done_o) done_cnt++;
      blk_take = blk_valid_i && blk_ready_o;
      rx_take  = rx_valid_i && rx_ready_o;
    end
  end

  // Host block source, controller word source and tx backpressure.
  always @(posedge clk) begin
    #1;
    if (blk_take && blkq.size() > 0) void'(blkq.pop_front());
    if (rx_take && rxq.size() > 0) void'(rxq.pop_front());
    blk_take = 1'b0;
    rx_take  = 1'b0;
    blk_valid_i = blk_en && (blkq.size() > 0);
    blk_i       = (blkq.size() > 0) ? blkq[0] : '0;
    rx_valid_i  = (rxq.size() > 0);
    rx_data_i   = (rxq.size() > 0) ? rxq[0] : '0;
    tx_ready_i  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic push_block(input logic [1:0] typ, input logic [DL-1:0] b);
    for (int w = 0; w < 4; w++) begin
      tx_exp_t e;
      e.typ  = typ;
      e.last = (w == 3);
      e.data = b[DL-1-32*w -: LW];
      txq.push_back(e);
    end
  endtask

  task automatic prepare_op(input logic [KL-1:0] k, input logic [KL-1:0] n,
                            input int na, input int nd, input bit fixed_tag);
    logic [DL-1:0] b;
    logic [DL-1:0] r;
    push_block(2'd0, k);
    push_block(2'd1, n);
    for (int i = 0; i < na; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      blkq.push_back(b);
      push_block(2'd2, b);
    end
    for (int i = 0; i < nd; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      blkq.push_back(b);
      push_block(2'd3, b);
      r = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < 4; w++) rxq.push_back(r[DL-1-32*w -: LW]);
      resq.push_back({1'b0, r});
    end
    if (fixed_tag) begin
      for (int w = 1; w <= 4; w++) rxq.push_back(LW'(w));
      resq.push_back({1'b1, 128'h00000001_00000002_00000003_00000004});
    end else begin
      r = {$urandom, $urandom, $urandom, $urandom};
      for (int w = 0; w < 4; w++) rxq.push_back(r[DL-1-32*w -: LW]);
      resq.push_back({1'b1, r});
    end
  endtask

  task automatic start_op(input logic [KL-1:0] k, input logic [KL-1:0] n,
                          input int na, input int nd);
    tx_cnt = 0; res_cnt = 0; done_cnt = 0;
    @(posedge clk); #2;
    key_i = k; nonce_i = n;
    ad_blocks_i = CW'(na); data_blocks_i = CW'(nd);
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < budget);
    if (!done_o) flag_fail({name, "_timeout"});
    @(posedge clk); #3;
    chk({name, "_busy_after"}, busy_o, 1'b0);
    chk({name, "_tx_left"}, txq.size(), 0);
    chk({name, "_res_left"}, resq.size(), 0);
    chk({name, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic wait_for_type(input string name, input logic [1:0] typ);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_valid_o && tx_type_o == typ) && n < 500);
    if (!(tx_valid_o && tx_type_o == typ)) flag_fail({name, "_timeout"});
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #2;
    rst = 1'b1;
    txq.delete(); resq.delete(); blkq.delete(); rxq.delete();
    repeat (cycles) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    int n;
    tbl[0] = '{na: 0,  nd: 0,  rnd: 1'b0, exp_words: 8,  exp_res: 1};
    tbl[1] = '{na: 2,  nd: 2,  rnd: 1'b0, exp_words: 24, exp_res: 3};
    tbl[2] = '{na: 1,  nd: 3,  rnd: 1'b1, exp_words: 24, exp_res: 4};
    tbl[3] = '{na: 15, nd: 0,  rnd: 1'b1, exp_words: 68, exp_res: 1};
    tbl[4] = '{na: 0,  nd: 15, rnd: 1'b1, exp_words: 68, exp_res: 16};

    // Reset defaults: two cycles of rst, every output low.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {blk_ready_o, res_valid_o, res_is_tag_o, res_o, busy_o, done_o,
         tx_valid_o, tx_data_o, tx_type_o, tx_last_o, rx_ready_o}, '0);
    #1 rst = 1'b0;

    // Directed key/nonce ordering with a fixed tag.
    prepare_op(128'h00112233_44556677_8899AABB_CCDDEEFF,
               128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0, 1'b1);
    start_op(128'h00112233_44556677_8899AABB_CCDDEEFF,
             128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0);
    wait_done("keynonce", 200);
    chk("keynonce_res_cnt", res_cnt, 1);

    // Table-driven operations.
    for (int i = 0; i < 5; i++) begin
      logic [KL-1:0] k;
      logic [KL-1:0] nn;
      k  = {$urandom, $urandom, $urandom, $urandom};
      nn = {$urandom, $urandom, $urandom, $urandom};
      rnd_rdy = tbl[i].rnd;
      prepare_op(k, nn, tbl[i].na, tbl[i].nd, 1'b0);
      start_op(k, nn, tbl[i].na, tbl[i].nd);
      wait_done($sformatf("vec%0d", i), 3000);
      chk($sformatf("vec%0d_words", i), tx_cnt, tbl[i].exp_words);
      chk($sformatf("vec%0d_results", i), res_cnt, tbl[i].exp_res);
    end
    rnd_rdy = 1'b0;

    // Block starvation in LOAD_DATA.
    blk_en = 1'b0;
    prepare_op(128'h1, 128'h2, 0, 1, 1'b0);
    start_op(128'h1, 128'h2, 0, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!blk_ready_o && n < 100);
    if (!blk_ready_o) flag_fail("starve_load_timeout");
    repeat (10) begin
      @(negedge clk);
      chk("starve_hold", {tx_valid_o, busy_o, blk_ready_o}, 3'b011);
    end
    blk_en = 1'b1;
    wait_done("starve", 200);

    // Start pulsed during SEND_DATA must be ignored.
    prepare_op(128'hAAAA, 128'hBBBB, 0, 2, 1'b0);
    start_op(128'hAAAA, 128'hBBBB, 0, 2);
    wait_for_type("ignstart", 2'd3);
    @(posedge clk); #2;
    key_i = 128'hDEAD_BEEF; ad_blocks_i = 4'd5; data_blocks_i = 4'd7;
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
    wait_done("ignstart", 400);
    chk("ignstart_words", tx_cnt, 16);
    repeat (4) begin
      @(negedge clk);
      chk("ignstart_idle", {tx_valid_o, busy_o}, 2'b00);
    end

    // Reset in the middle of SEND_AD.
    prepare_op(128'h5, 128'h6, 2, 0, 1'b0);
    start_op(128'h5, 128'h6, 2, 0);
    wait_for_type("midrst", 2'd2);
    do_reset(1);
    @(negedge clk);
    chk("midrst_idle", {tx_valid_o, busy_o, blk_ready_o, rx_ready_o}, 4'b0000);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_quiet", {tx_valid_o, res_valid_o, done_o}, 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
